// File: rtl/iter_div.sv
// iter_div: radix-2 restoring divider (DIV/DIVU) with its own sequencing FSM; result is {remainder, quotient}.
// Latency: ready_o high after edge DATA_W+1 (edge 0 samples start_i), after edge 1 for divide-by-zero,
// after edge 0 for the |op1|<|op2| early exit. Backpressure: start_i is held until ready_o; dropping it releases the result.
// Optional feature macro: DIV_EARLY_TERM_EN (finish at edge 0 when the dividend magnitude is below the divisor's).
module iter_div #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  // quo_r starts as |dividend| and is shifted out MSB first while quotient bits shift in at the LSB
  logic [DATA_W-1:0]   quo_r, quo_nxt;
  logic [DATA_W-1:0]   rem_r, rem_nxt;
  logic [DATA_W-1:0]   dvs_r, dvs_nxt;
  // Sign corrections are resolved at capture so the final edge only needs the two flags
  logic                neg_quo_r, neg_quo_nxt;
  logic                neg_rem_r, neg_rem_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic                ready_nxt;

  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W:0]     shifted, trial;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  // Magnitudes of the incoming operands; only negated for DIV with the sign bit set
  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  // One restoring step: bring in the next dividend bit, then trial-subtract; trial[DATA_W] is the borrow
  assign shifted = {rem_r, quo_r[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvs_r};

  // Final sign fix; -2^(N-1)/-1 wraps naturally to 2^(N-1) with no flag
  assign quo_fix = neg_quo_r ? (~quo_r + 1'b1) : quo_r;
  assign rem_fix = neg_rem_r ? (~rem_r + 1'b1) : rem_r;

  // Next-state and next-output decode; every target holds its value unless a state says otherwise
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    quo_nxt     = quo_r;
    rem_nxt     = rem_r;
    dvs_nxt     = dvs_r;
    neg_quo_nxt = neg_quo_r;
    neg_rem_nxt = neg_rem_r;
    result_nxt  = result_o;
    ready_nxt   = ready_o;
    case (state)
      FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        // A simultaneous annul cancels the request before it is accepted
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = BYZERO;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (op1_abs < op2_abs) begin
            state_nxt  = END;
            result_nxt = {opdata1_i, {DATA_W{1'b0}}};
            ready_nxt  = 1'b1;
          end
`endif
          else begin
            state_nxt   = ON;
            cnt_nxt     = '0;
            quo_nxt     = op1_abs;
            rem_nxt     = '0;
            dvs_nxt     = op2_abs;
            neg_quo_nxt = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_nxt = signed_div_i && opdata1_i[DATA_W-1];
          end
        end
      end
      BYZERO: begin
        state_nxt  = END;
        result_nxt = '0;
        ready_nxt  = 1'b1;
      end
      ON: begin
        if (annul_i) begin
          state_nxt  = FREE;
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end else if (cnt < CNT_W'(DATA_W)) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (!trial[DATA_W]) begin
            rem_nxt = trial[DATA_W-1:0];
            quo_nxt = {quo_r[DATA_W-2:0], 1'b1};
          end else begin
            rem_nxt = shifted[DATA_W-1:0];
            quo_nxt = {quo_r[DATA_W-2:0], 1'b0};
          end
        end else begin
          state_nxt  = END;
          result_nxt = {rem_fix, quo_fix};
          ready_nxt  = 1'b1;
        end
      end
      END: begin
        // Result stays put until EX drops its request; annul has no effect here
        if (!start_i) begin
          state_nxt  = FREE;
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt  = FREE;
        result_nxt = '0;
        ready_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; synchronous active-low reset clears everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FREE;
      cnt       <= '0;
      quo_r     <= '0;
      rem_r     <= '0;
      dvs_r     <= '0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      quo_r     <= quo_nxt;
      rem_r     <= rem_nxt;
      dvs_r     <= dvs_nxt;
      neg_quo_r <= neg_quo_nxt;
      neg_rem_r <= neg_rem_nxt;
      result_o  <= result_nxt;
      ready_o   <= ready_nxt;
    end
  end

endmodule
